res_port_arbiter: RTL and testbench
===================================

# res_port_arbiter

Two-requester arbiter that shares the single-port 16384×8 distance-transform result RAM (res memory) between the DT engine (requester 0) and the host load/dump engine (requester 1). It grants ownership in bursts with round-robin tie-breaking, supports a lock for atomic read-modify-write sequences, registers all memory-side strobes, and returns read data to the requester that issued the read. It sits between both engines and the res memory pins.

## Interface
- AW, 14, res memory address width (128×128 image)
- DW, 8, res memory data width
- MAX_BURST, 16, accepted ops per grant before yielding to a waiting requester (range 1..255)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  requester wants an access this cycle
- lock0 / lock1  in  1  hold ownership past MAX_BURST (ignored when not owner)
- we0 / we1  in  1  1 = write, 0 = read; qualifies reqN
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  registered ownership; op accepted in a cycle where reqN && gntN
- rvalid0 / rvalid1  out  1  one-cycle pulse, rdataN valid
- rdata0 / rdata1  out  DW  read return data
- res_rd  out  1  memory read strobe
- res_wr  out  1  memory write strobe
- res_addr  out  AW  memory address
- res_do  out  DW  memory write data
- res_di  in  DW  memory read data, valid during the cycle res_rd is high
- busy  out  1  high when state ≠ IDLE or an op is in flight

## Operation
- FSM states: IDLE, OWN0, OWN1. gnt0 = (state==OWN0), gnt1 = (state==OWN1); never both high.
- Priority pointer prio (1 bit) picks the winner when req0 && req1 in IDLE; set to the non-granted requester on every grant.
- IDLE: req0 && req1 → OWN[prio]; only reqN → OWNN; none → IDLE. No op is accepted in IDLE.
- OWNi, accept = reqi. burst_cnt (8 bit) clears on entry to OWNi and increments per accept, saturating at MAX_BURST.
- Release from OWNi when: (a) !reqi, or (b) accept && burst_cnt+1 ≥ MAX_BURST && !locki && reqj.
- On release: reqj → OWNj directly (no IDLE bubble); else IDLE.
- While locki is high the owner is never preempted; burst_cnt still saturates.
- Accepted op registered onto the memory pins next cycle: res_rd = !we, res_wr = we, res_addr = addr, res_do = wdata (0 on reads). res_rd and res_wr never high together; both 0 in cycles with no accept.
- Read-source tag registered with the strobe; in the following cycle rvalid[tag] pulses and rdata[tag] = the res_di sampled during the res_rd cycle. The other rdata holds its previous value.
- Writes produce no response.
- Asynchronous reset: state IDLE, prio 0 (DT engine wins the first tie), burst_cnt 0, all gnt/rvalid/res_rd/res_wr/busy 0, res_addr/res_do/rdata 0. In-flight reads are dropped with no rvalid.

## Timing
- Request to first grant: req rises in cycle T in IDLE → gnt high in T+1 → first accept in T+1.
- Accept at T → memory strobe at T+1 → rvalid/rdata at T+2. Read latency 2, fully pipelined: one op per cycle per owner.
- Handover: the last accept of owner i is at T; gntj is high at T+1, and j's first op reaches the pins at T+2. This gives back-to-back memory cycles with no idle.
- A request that drops in the same cycle ownership arrives loses that grant. The FSM releases next cycle via rule (a).
- busy falls only after the final rvalid.

## Test plan
- Single requester: req0 reads addr 0x0081 while memory holds 0x05. Required: gnt0 at T+1, res_rd/res_addr=0x0081 at T+2, rvalid0 with rdata0=0x05 at T+3, busy low at T+4.
- Tie after reset: req0 and req1 rise together. Required: OWN0 first, prio=1. After req0 drops, OWN1 with no idle cycle. The next tie grants requester 0 again only after requester 1 has owned.
- Burst preemption with MAX_BURST=4: req0 streams 10 writes while req1 waits. Required: exactly 4 res_wr for requester 0, then gnt1. Requester 0 regains the grant after requester 1 drops.
- Lock: same as the preemption case with lock0 high. Required: all 10 writes complete before gnt1. burst_cnt holds at 4.
- Interleaved reads: the last accept of owner 0 is a read and owner 1's first op is a read. Required: rvalid0 then rvalid1 on consecutive cycles, each with the correct data and never cross-routed.
- Reset mid-read: assert reset the cycle after a read accept. Required: all outputs 0 immediately, no rvalid after release, and state IDLE.

Source files
------------

// File: rtl/res_port_arbiter.sv
// res_port_arbiter: two-requester burst arbiter for the single-port
// distance-transform result RAM. Round-robin on ties, lockable ownership,
// registered memory strobes and tag-routed read returns.
module res_port_arbiter #(
    parameter int unsigned AW        = 14,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          res_rd,
    output logic          res_wr,
    output logic [AW-1:0] res_addr,
    output logic [DW-1:0] res_do,
    input  logic [DW-1:0] res_di,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [8:0] MAXB = 9'(MAX_BURST);

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic [7:0]    burst_q, burst_d;

    logic          own1, accept, own_req, own_lock, oth_req;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    logic          res_rd_q, res_wr_q, tag_q;
    logic [AW-1:0] res_addr_q;
    logic [DW-1:0] res_do_q;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    // Owner-side view of the requests and the op accepted this cycle
    always_comb begin
        own1      = (state_q == OWN1);
        own_req   = own1 ? req1  : req0;
        own_lock  = own1 ? lock1 : lock0;
        oth_req   = own1 ? req0  : req1;
        accept    = (state_q == OWN0 && req0) || (state_q == OWN1 && req1);
        acc_we    = own1 ? we1    : we0;
        acc_addr  = own1 ? addr1  : addr0;
        acc_wdata = own1 ? wdata1 : wdata0;
    end

    // Next-state: grant selection, burst counting and release/handover
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = prio_q ? OWN1 : OWN0;
                    prio_d  = ~prio_q;
                    burst_d = '0;
                end else if (req0) begin
                    state_d = OWN0;
                    prio_d  = 1'b1;
                    burst_d = '0;
                end else if (req1) begin
                    state_d = OWN1;
                    prio_d  = 1'b0;
                    burst_d = '0;
                end
            end
            default: begin
                if (accept && ({1'b0, burst_q} < MAXB)) begin
                    burst_d = burst_q + 8'd1;
                end
                if (!own_req ||
                    (accept && ({1'b0, burst_q} + 9'd1 >= MAXB) && !own_lock && oth_req)) begin
                    if (oth_req) begin
                        // Direct handover; prio points back at the yielding owner
                        state_d = own1 ? OWN0 : OWN1;
                        prio_d  = own1;
                        burst_d = '0;
                    end else begin
                        state_d = IDLE;
                        burst_d = '0;
                    end
                end
            end
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            burst_q <= burst_d;
        end
    end

    // Memory-side strobe stage plus read-source tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_rd_q   <= 1'b0;
            res_wr_q   <= 1'b0;
            tag_q      <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
        end else begin
            res_rd_q <= accept && !acc_we;
            res_wr_q <= accept && acc_we;
            if (accept) begin
                tag_q      <= own1;
                res_addr_q <= acc_addr;
                res_do_q   <= acc_we ? acc_wdata : '0;
            end
        end
    end

    // Read return stage: route sampled res_di to the tagged requester
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= res_rd_q && !tag_q;
            rvalid1_q <= res_rd_q && tag_q;
            if (res_rd_q && !tag_q) rdata0_q <= res_di;
            if (res_rd_q && tag_q)  rdata1_q <= res_di;
        end
    end

    assign gnt0     = (state_q == OWN0);
    assign gnt1     = (state_q == OWN1);
    assign res_rd   = res_rd_q;
    assign res_wr   = res_wr_q;
    assign res_addr = res_addr_q;
    assign res_do   = res_do_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = (state_q != IDLE) || res_rd_q || res_wr_q || rvalid0_q || rvalid1_q;

endmodule

// File: tb/tb_res_port_arbiter.sv
// Scoreboard bench for res_port_arbiter (MAX_BURST overridden to 4).
module tb_res_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  data;
    } op_t;

    typedef struct packed {
        logic gnt0, gnt1, rd, wr, rv0, rv1, busy;
    } tr_t;

    logic        clk, reset;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [13:0] addr0, addr1, res_addr;
    logic [7:0]  wdata0, wdata1, rdata0, rdata1, res_do, res_di;
    logic        gnt0, gnt1, rvalid0, rvalid1, res_rd, res_wr, busy;

    logic [7:0]  mem [0:16383];
    op_t         q0[$], q1[$], exp_mem[$];
    logic [7:0]  exp_rd0[$], exp_rd1[$];
    tr_t         trace[$];
    logic        acc0, acc1;
    int          checks = 0;
    int          failures = 0;

    res_port_arbiter #(.AW(14), .DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr),
        .res_do(res_do), .res_di(res_di), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign res_di = res_rd ? mem[res_addr] : 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic op_t mk(input logic we, input logic [13:0] a, input logic [7:0] d);
        op_t o;
        o.we = we; o.addr = a; o.data = d;
        return o;
    endfunction

    // Acceptance seen just before the edge
    always @(negedge clk) begin
        acc0 = req0 && gnt0;
        acc1 = req1 && gnt1;
    end

    // Requester drivers: present the head op until it is accepted
    initial begin
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        forever begin
            @(posedge clk); #1;
            if (acc0 && q0.size() != 0) void'(q0.pop_front());
            if (acc1 && q1.size() != 0) void'(q1.pop_front());
            if (q0.size() != 0) begin
                req0 = 1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
            end else req0 = 0;
            if (q1.size() != 0) begin
                req1 = 1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
            end else req1 = 0;
        end
    end

    // Monitor: records a per-cycle trace and pops expectations on every response
    always @(negedge clk) begin
        op_t e;
        if (reset) begin
            trace.push_back('{gnt0, gnt1, res_rd, res_wr, rvalid0, rvalid1, busy});
            if (res_rd && res_wr) chk("rd_wr_exclusive", 32'(res_rd & res_wr), 0);
            if (res_rd || res_wr) begin
                if (exp_mem.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_strobe rd=%0b wr=%0b addr=%0h expected=none", res_rd, res_wr, res_addr);
                end else begin
                    e = exp_mem.pop_front();
                    chk("strobe_kind", 32'(res_wr), 32'(e.we));
                    chk("strobe_addr", 32'(res_addr), 32'(e.addr));
                    chk("strobe_wdata", 32'(res_do), e.we ? 32'(e.data) : 0);
                end
            end
            if (rvalid0) begin
                if (exp_rd0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rvalid0 rdata0=%0h expected=none", rdata0);
                end else chk("rdata0", 32'(rdata0), 32'(exp_rd0.pop_front()));
            end
            if (rvalid1) begin
                if (exp_rd1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rvalid1 rdata1=%0h expected=none", rdata1);
                end else chk("rdata1", 32'(rdata1), 32'(exp_rd1.pop_front()));
            end
        end
    end

    task automatic start_test();
        @(negedge clk); #2;
        trace.delete();
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("drain_within_budget", 32'(n < 200), 1);
        repeat (4) @(negedge clk);
        chk("leftover_mem", 32'(exp_mem.size()), 0);
        chk("leftover_rd0", 32'(exp_rd0.size()), 0);
        chk("leftover_rd1", 32'(exp_rd1.size()), 0);
    endtask

    function automatic int first_gnt1();
        for (int i = 0; i < trace.size(); i++) if (trace[i].gnt1) return i;
        return -1;
    endfunction

    // Two writes from each side raised in the same cycle
    task automatic tie(input bit first1);
        int unsigned gaps = 0;
        start_test();
        for (int k = 0; k < 2; k++) begin
            q0.push_back(mk(1'b1, 14'h0100 + 14'(k), 8'h10 + 8'(k)));
            q1.push_back(mk(1'b1, 14'h0200 + 14'(k), 8'h20 + 8'(k)));
        end
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 2; k++) begin
                if ((p == 0) != first1) exp_mem.push_back(mk(1'b1, 14'h0100 + 14'(k), 8'h10 + 8'(k)));
                else                    exp_mem.push_back(mk(1'b1, 14'h0200 + 14'(k), 8'h20 + 8'(k)));
            end
        end
        drain();
        chk("tie_first_owner",  32'(first1 ? trace[1].gnt1 : trace[1].gnt0), 1);
        chk("tie_second_owner", 32'(first1 ? trace[4].gnt0 : trace[4].gnt1), 1);
        for (int i = 1; i <= 6; i++) if (!(trace[i].gnt0 || trace[i].gnt1)) gaps++;
        chk("tie_no_idle_handover", gaps, 0);
    endtask

    initial begin
        reset = 1'b0; lock0 = 0; lock1 = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h0081] = 8'h05;
        for (int k = 0; k < 5; k++) mem[14'h0500 + 14'(k)] = 8'hC0 + 8'(k);
        mem[14'h0580] = 8'hD7;
        mem[14'h0581] = 8'h3C;

        repeat (3) @(posedge clk); #1;
        chk("rst_gnt",    32'({gnt1, gnt0}), 0);
        chk("rst_strobe", 32'({res_rd, res_wr}), 0);
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_addr",   32'(res_addr), 0);
        chk("rst_rdata",  32'({rdata1, rdata0, res_do}), 0);
        @(negedge clk); reset = 1'b1;

        // Ties: 0 wins after reset, again after 1 has owned
        tie(1'b0);
        tie(1'b0);

        // Single read, then a tie that requester 1 must win
        start_test();
        q0.push_back(mk(1'b0, 14'h0081, 8'h00));
        exp_mem.push_back(mk(1'b0, 14'h0081, 8'h00));
        exp_rd0.push_back(8'h05);
        drain();
        chk("single_no_gnt_T",   32'(trace[0].gnt0), 0);
        chk("single_gnt_T1",     32'(trace[1].gnt0), 1);
        chk("single_rd_T2",      32'(trace[2].rd), 1);
        chk("single_rvalid_T3",  32'(trace[3].rv0), 1);
        chk("single_busy_T3",    32'(trace[3].busy), 1);
        chk("single_busy_low_T4", 32'(trace[4].busy), 0);
        tie(1'b1);

        // Burst preemption at 4 accepts
        start_test();
        for (int k = 0; k < 10; k++) q0.push_back(mk(1'b1, 14'h0300 + 14'(k), 8'(k)));
        for (int k = 0; k < 4; k++)  exp_mem.push_back(mk(1'b1, 14'h0300 + 14'(k), 8'(k)));
        for (int k = 0; k < 2; k++)  exp_mem.push_back(mk(1'b1, 14'h0380 + 14'(k), 8'hA0 + 8'(k)));
        for (int k = 4; k < 10; k++) exp_mem.push_back(mk(1'b1, 14'h0300 + 14'(k), 8'(k)));
        repeat (2) @(negedge clk); #2;
        for (int k = 0; k < 2; k++) q1.push_back(mk(1'b1, 14'h0380 + 14'(k), 8'hA0 + 8'(k)));
        drain();
        chk("burst_first_gnt1", 32'(first_gnt1()), 5);
        chk("burst_regain_gnt0", 32'(trace[8].gnt0), 1);

        // Locked owner is never preempted
        lock0 = 1;
        start_test();
        for (int k = 0; k < 10; k++) begin
            q0.push_back(mk(1'b1, 14'h0400 + 14'(k), 8'h40 + 8'(k)));
            exp_mem.push_back(mk(1'b1, 14'h0400 + 14'(k), 8'h40 + 8'(k)));
        end
        for (int k = 0; k < 2; k++) exp_mem.push_back(mk(1'b1, 14'h0480 + 14'(k), 8'hB0 + 8'(k)));
        repeat (2) @(negedge clk); #2;
        for (int k = 0; k < 2; k++) q1.push_back(mk(1'b1, 14'h0480 + 14'(k), 8'hB0 + 8'(k)));
        drain();
        chk("lock_first_gnt1", 32'(first_gnt1()), 12);
        lock0 = 0;

        // Read handover: owner 0's last read then owner 1's first read
        start_test();
        for (int k = 0; k < 5; k++) q0.push_back(mk(1'b0, 14'h0500 + 14'(k), 8'h00));
        for (int k = 0; k < 4; k++) exp_mem.push_back(mk(1'b0, 14'h0500 + 14'(k), 8'h00));
        exp_mem.push_back(mk(1'b0, 14'h0580, 8'h00));
        exp_mem.push_back(mk(1'b0, 14'h0504, 8'h00));
        for (int k = 0; k < 5; k++) exp_rd0.push_back(8'hC0 + 8'(k));
        exp_rd1.push_back(8'hD7);
        repeat (2) @(negedge clk); #2;
        q1.push_back(mk(1'b0, 14'h0580, 8'h00));
        drain();
        chk("ilv_rvalid0_c6", 32'({trace[6].rv1, trace[6].rv0}), 1);
        chk("ilv_rvalid1_c7", 32'({trace[7].rv1, trace[7].rv0}), 2);

        // Reset during the strobe cycle of a read: nothing may come back
        start_test();
        q0.push_back(mk(1'b0, 14'h0581, 8'h00));
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        chk("rstmid_strobe_present", 32'(res_rd), 1);
        reset = 1'b0;
        #1;
        chk("rstmid_strobe_clear", 32'({res_rd, res_wr}), 0);
        chk("rstmid_gnt_clear",    32'({gnt1, gnt0}), 0);
        chk("rstmid_busy_clear",   32'(busy), 0);
        chk("rstmid_addr_clear",   32'(res_addr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstmid_idle",   32'({gnt1, gnt0}), 0);
        chk("rstmid_busy",   32'(busy), 0);
        chk("rstmid_rdata0", 32'(rdata0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
